// File: rtl/rggen_dispatcher_if.sv
// rggen_dispatcher_if: request/target handshake bundle for rggen_dispatcher.
//   i_valid/o_ready      : upstream valid/ready handshake
//   i_select/i_data      : one-hot target select and payload, sampled on accept
//   o_valid/i_ready      : per-target valid and per-target ready
//   o_data               : per-target payload, slot k = o_data[WIDTH*k +: WIDTH]
//   o_busy/o_error       : request outstanding / malformed-or-timeout pulse
// Signal names are from the dispatcher's point of view (slave modport).
interface rggen_dispatcher_if #(
  parameter int WIDTH   = 1,
  parameter int ENTRIES = 2
);
  logic                     i_valid;
  logic                     o_ready;
  logic [ENTRIES-1:0]       i_select;
  logic [WIDTH-1:0]         i_data;
  logic [ENTRIES-1:0]       o_valid;
  logic [ENTRIES-1:0]       i_ready;
  logic [WIDTH*ENTRIES-1:0] o_data;
  logic                     o_busy;
  logic                     o_error;

  modport slave (
    input  i_valid, i_select, i_data, i_ready,
    output o_ready, o_valid, o_data, o_busy, o_error
  );

  modport master (
    output i_valid, i_select, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_busy, o_error
  );
endinterface

// File: rtl/rggen_dispatcher.sv
// rggen_dispatcher: forwards one accepted request (one-hot select + payload)
// to exactly one of ENTRIES targets and holds that target's valid until its
// ready returns. Malformed selects and (optionally) unanswered targets raise
// a one-cycle registered error pulse.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : rggen_dispatcher_if.slave (handshake, select, payload, targets)
// Parameters: WIDTH payload bits, ENTRIES targets (>=1), TIMEOUT cycles
// (0 disables the abort).

// Per-target payload slot: payload is only visible on the active target.
module rggen_dispatcher_slot #(
  parameter int WIDTH = 1
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  assign o_data = i_en ? i_data : '0;
endmodule

module rggen_dispatcher #(
  parameter int WIDTH   = 1,
  parameter int ENTRIES = 2,
  parameter int TIMEOUT = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  rggen_dispatcher_if.slave bus
);
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DISPATCH = 1'b1;

  logic [0:0]                    r_state;
  logic [ENTRIES-1:0]            r_select;
  logic [WIDTH-1:0]              r_data;
  logic                          r_error;

  logic                          w_idle;
  logic                          w_accept;
  logic                          w_onehot;
  logic                          w_done;
  logic                          w_abort;
  logic [ENTRIES-1:0]            w_valid;
  logic [ENTRIES-1:0][WIDTH-1:0] w_slot;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && bus.i_valid;
  assign w_onehot = $onehot(bus.i_select);
  // Only the captured target's ready bit can complete the transfer.
  assign w_done   = !w_idle && |(r_select & bus.i_ready);

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
      logic [CW-1:0] r_cnt;

      // Counts dispatch cycles without the active ready; wraps harmlessly on
      // the abort edge because accept always clears it.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)               r_cnt <= '0;
        else if (w_accept)          r_cnt <= '0;
        else if (!w_idle && !w_done) r_cnt <= r_cnt + CW'(1);
      end

      // Completion on the limit cycle takes priority over the abort.
      assign w_abort = !w_idle && !w_done && (r_cnt == LIMIT);
    end else begin : g_no_tmo
      assign w_abort = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_select <= '0;
      r_data   <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= (w_accept && !w_onehot) || w_abort;
      if (w_accept && w_onehot) begin
        r_state  <= ST_DISPATCH;
        r_select <= bus.i_select;
        r_data   <= bus.i_data;
      end else if (w_done || w_abort) begin
        r_state  <= ST_IDLE;
      end
    end
  end

  // Outputs come from registers and state only; no path from i_ready.
  assign w_valid = w_idle ? '0 : r_select;

  generate
    for (genvar k = 0; k < ENTRIES; k++) begin : g_slot
      rggen_dispatcher_slot #(.WIDTH(WIDTH)) u_slot (
        .i_en   (w_valid[k]),
        .i_data (r_data),
        .o_data (w_slot[k])
      );
    end
  endgenerate

  assign bus.o_ready = w_idle;
  assign bus.o_busy  = !w_idle;
  assign bus.o_valid = w_valid;
  assign bus.o_data  = w_slot;
  assign bus.o_error = r_error;
endmodule

// File: tb/tb_rggen_dispatcher.sv
// Bench for rggen_dispatcher: three instances (4 targets untimed, 4 targets
// with TIMEOUT=3, single target) driven by directed scenarios and a random
// run checked against a transaction-level model.
module tb_rggen_dispatcher;
  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 i_clk = ~i_clk;

  rggen_dispatcher_if #(.WIDTH(8), .ENTRIES(4)) b4 ();
  rggen_dispatcher_if #(.WIDTH(8), .ENTRIES(4)) bt ();
  rggen_dispatcher_if #(.WIDTH(8), .ENTRIES(1)) b1 ();

  rggen_dispatcher #(.WIDTH(8), .ENTRIES(4), .TIMEOUT(0)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b4));
  rggen_dispatcher #(.WIDTH(8), .ENTRIES(4), .TIMEOUT(3)) dut_t (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bt));
  rggen_dispatcher #(.WIDTH(8), .ENTRIES(1), .TIMEOUT(0)) dut_1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b1));

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_all();
    b4.i_valid = 1'b0; b4.i_select = '0; b4.i_data = '0; b4.i_ready = '0;
    bt.i_valid = 1'b0; bt.i_select = '0; bt.i_data = '0; bt.i_ready = '0;
    b1.i_valid = 1'b0; b1.i_select = '0; b1.i_data = '0; b1.i_ready = '0;
  endtask

  task automatic test_reset();
    logic [38:0] g;
    logic [11:0] g1;
    @(negedge i_clk);
    g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid, b4.o_data};
    vectors++;
    if (g !== {3'b100, 4'h0, 32'h0}) begin
      miscompares++; $display("FAIL reset_a got %h exp %h", g, {3'b100, 36'h0});
    end
    g = {bt.o_ready, bt.o_busy, bt.o_error, bt.o_valid, bt.o_data};
    vectors++;
    if (g !== {3'b100, 4'h0, 32'h0}) begin
      miscompares++; $display("FAIL reset_t got %h exp %h", g, {3'b100, 36'h0});
    end
    g1 = {b1.o_ready, b1.o_busy, b1.o_error, b1.o_valid, b1.o_data};
    vectors++;
    if (g1 !== {3'b100, 1'b0, 8'h0}) begin
      miscompares++; $display("FAIL reset_1 got %h exp %h", g1, {3'b100, 9'h0});
    end
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [38:0] g;
    b4.i_valid = 1'b1; b4.i_select = 4'b0100; b4.i_data = 8'hA5; b4.i_ready = 4'b0000;
    step();
    b4.i_valid = 1'b0; b4.i_select = '0; b4.i_data = '0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) b4.i_ready = 4'b0100;
      g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid, b4.o_data};
      vectors++;
      if (g !== {3'b010, 4'b0100, 32'h00A5_0000}) begin
        miscompares++; $display("FAIL basic_hold c%0d got %h exp %h", c, g, {3'b010, 4'b0100, 32'h00A5_0000});
      end
      step();
    end
    b4.i_ready = '0;
    g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid, b4.o_data};
    vectors++;
    if (g !== {3'b100, 36'h0}) begin
      miscompares++; $display("FAIL basic_done got %h exp %h", g, {3'b100, 36'h0});
    end
  endtask

  task automatic test_wrong_ready();
    logic [6:0] g;
    b4.i_valid = 1'b1; b4.i_select = 4'b0010; b4.i_data = 8'h3E;
    step();
    b4.i_valid = 1'b0;
    b4.i_ready = 4'b1101;
    step();
    g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid};
    vectors++;
    if (g !== {3'b010, 4'b0010}) begin
      miscompares++; $display("FAIL wrong_ready_hold got %h exp %h", g, {3'b010, 4'b0010});
    end
    vectors++;
    if (b4.o_data !== 32'h0000_3E00) begin
      miscompares++; $display("FAIL wrong_ready_data got %h exp %h", b4.o_data, 32'h0000_3E00);
    end
    b4.i_ready = 4'b0010;
    step();
    b4.i_ready = '0;
    g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid};
    vectors++;
    if (g !== {3'b100, 4'b0000}) begin
      miscompares++; $display("FAIL wrong_ready_done got %h exp %h", g, {3'b100, 4'b0000});
    end
  endtask

  task automatic test_malformed();
    logic [3:0] sels [2];
    logic [6:0] g;
    sels[0] = 4'b0000; sels[1] = 4'b0011;
    for (int s = 0; s < 2; s++) begin
      b4.i_valid = 1'b1; b4.i_select = sels[s]; b4.i_data = 8'hFF;
      step();
      b4.i_valid = 1'b0; b4.i_select = '0;
      g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid};
      vectors++;
      if (g !== {3'b101, 4'b0000}) begin
        miscompares++; $display("FAIL malformed_pulse s%0d got %h exp %h", s, g, {3'b101, 4'b0000});
      end
      step();
      g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid};
      vectors++;
      if (g !== {3'b100, 4'b0000}) begin
        miscompares++; $display("FAIL malformed_after s%0d got %h exp %h", s, g, {3'b100, 4'b0000});
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [6:0] g;
    bt.i_valid = 1'b1; bt.i_select = 4'b0001; bt.i_data = 8'h77; bt.i_ready = '0;
    step();
    bt.i_valid = 1'b0; bt.i_select = '0;
    n = 0;
    while (bt.o_valid !== 4'b0000 && n < 10) begin
      n++;
      step();
    end
    vectors++;
    if (n != 3) begin
      miscompares++; $display("FAIL timeout_len got %0d exp %0d", n, 3);
    end
    g = {bt.o_ready, bt.o_busy, bt.o_error, bt.o_valid};
    vectors++;
    if (g !== {3'b101, 4'b0000}) begin
      miscompares++; $display("FAIL timeout_err got %h exp %h", g, {3'b101, 4'b0000});
    end
    step();
    vectors++;
    if (bt.o_error !== 1'b0) begin
      miscompares++; $display("FAIL timeout_err_width got %b exp 0", bt.o_error);
    end
    // Second run: ready arrives on the limit cycle, completion wins.
    bt.i_valid = 1'b1; bt.i_select = 4'b0001; bt.i_data = 8'h78;
    step();
    bt.i_valid = 1'b0; bt.i_select = '0;
    step();
    step();
    bt.i_ready = 4'b0001;
    vectors++;
    if (bt.o_valid !== 4'b0001) begin
      miscompares++; $display("FAIL timeout_race_hold got %h exp %h", bt.o_valid, 4'b0001);
    end
    step();
    bt.i_ready = '0;
    g = {bt.o_ready, bt.o_busy, bt.o_error, bt.o_valid};
    vectors++;
    if (g !== {3'b100, 4'b0000}) begin
      miscompares++; $display("FAIL timeout_race_done got %h exp %h", g, {3'b100, 4'b0000});
    end
    step();
    vectors++;
    if (bt.o_error !== 1'b0) begin
      miscompares++; $display("FAIL timeout_race_noerr got %b exp 0", bt.o_error);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] g;
    b4.i_valid = 1'b1; b4.i_select = 4'b1000; b4.i_data = 8'hC3;
    step();
    b4.i_valid = 1'b0; b4.i_select = '0;
    vectors++;
    if (b4.o_busy !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_busy got %b exp 1", b4.o_busy);
    end
    #2 i_rst_n = 1'b0;
    #1;
    g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid};
    vectors++;
    if (g !== {3'b100, 4'b0000} || b4.o_data !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_async got %h/%h exp %h/0", g, b4.o_data, {3'b100, 4'b0000});
    end
    #1 i_rst_n = 1'b1;
    step();
    g = {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid};
    vectors++;
    if (g !== {3'b100, 4'b0000}) begin
      miscompares++; $display("FAIL rstmid_release got %h exp %h", g, {3'b100, 4'b0000});
    end
    b4.i_valid = 1'b1; b4.i_select = 4'b0001; b4.i_data = 8'h5A;
    step();
    b4.i_valid = 1'b0; b4.i_select = '0;
    vectors++;
    if (b4.o_valid !== 4'b0001 || b4.o_data !== 32'h0000_005A) begin
      miscompares++; $display("FAIL rstmid_redispatch got %h/%h exp 1/5a", b4.o_valid, b4.o_data);
    end
    b4.i_ready = 4'b0001;
    step();
    b4.i_ready = '0;
    vectors++;
    if (b4.o_ready !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_complete got %b exp 1", b4.o_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rv [5];
    logic [1:0] g;
    exp_rv[0] = 2'b10; exp_rv[1] = 2'b01; exp_rv[2] = 2'b10;
    exp_rv[3] = 2'b01; exp_rv[4] = 2'b10;
    b1.i_ready = 1'b1; b1.i_valid = 1'b1; b1.i_select = 1'b1; b1.i_data = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) b1.i_valid = 1'b0;
      g = {b1.o_ready, b1.o_valid};
      vectors++;
      if (g !== exp_rv[c]) begin
        miscompares++; $display("FAIL b2b c%0d got %b exp %b", c, g, exp_rv[c]);
      end
      if (c == 1) begin
        vectors++;
        if (b1.o_data !== 8'h3C) begin
          miscompares++; $display("FAIL b2b_data got %h exp 3c", b1.o_data);
        end
      end
      step();
    end
    // Single-target block still rejects an empty select.
    b1.i_valid = 1'b1; b1.i_select = 1'b0;
    step();
    b1.i_valid = 1'b0; b1.i_ready = 1'b0;
    vectors++;
    if ({b1.o_error, b1.o_valid, b1.o_ready} !== 3'b101) begin
      miscompares++; $display("FAIL e1_malformed got %b exp 101", {b1.o_error, b1.o_valid, b1.o_ready});
    end
    step();
  endtask

  // Transaction-level model: a pending request has a target, payload and age.
  task automatic test_random();
    bit          m_busy [2];
    int          m_tgt  [2];
    logic [7:0]  m_data [2];
    int          m_age  [2];
    bit          m_err  [2];
    int          tmo    [2];
    logic [38:0] g, e;
    logic [31:0] ed;
    logic        v;
    logic [3:0]  sel, rdy;
    logic [7:0]  dat;
    tmo[0] = 0; tmo[1] = 3;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_tgt[d] = 0; m_data[d] = '0; m_age[d] = 0; m_err[d] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        ed = '0;
        if (m_busy[d]) ed[m_tgt[d]*8 +: 8] = m_data[d];
        e = {!m_busy[d], m_busy[d], m_err[d],
             (m_busy[d] ? 4'(1 << m_tgt[d]) : 4'b0000), ed};
        g = (d == 0) ? {b4.o_ready, b4.o_busy, b4.o_error, b4.o_valid, b4.o_data}
                     : {bt.o_ready, bt.o_busy, bt.o_error, bt.o_valid, bt.o_data};
        vectors++;
        if (g !== e) begin
          miscompares++; $display("FAIL random d%0d cyc%0d got %h exp %h", d, cyc, g, e);
        end
      end
      v   = ($urandom_range(0, 1) == 1);
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'(1 << $urandom_range(0, 3));
      dat = 8'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      b4.i_valid = v; b4.i_select = sel; b4.i_data = dat; b4.i_ready = rdy;
      bt.i_valid = v; bt.i_select = sel; bt.i_data = dat; bt.i_ready = rdy;
      for (int d = 0; d < 2; d++) begin
        if (!m_busy[d]) begin
          m_err[d] = 0;
          if (v) begin
            if ($countones(sel) == 1) begin
              m_busy[d] = 1; m_data[d] = dat; m_age[d] = 0;
              for (int k = 0; k < 4; k++) if (sel[k]) m_tgt[d] = k;
            end else begin
              m_err[d] = 1;
            end
          end
        end else begin
          m_err[d] = 0;
          if (rdy[m_tgt[d]]) begin
            m_busy[d] = 0;
          end else begin
            m_age[d]++;
            if (tmo[d] > 0 && m_age[d] == tmo[d]) begin
              m_busy[d] = 0; m_err[d] = 1;
            end
          end
        end
      end
      step();
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_basic();
    test_wrong_ready();
    test_malformed();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    idle_all();
    step();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
